// File: rtl/as1802_pkg.sv
// as1802_pkg: shared types and default sizes for the as1802 external-bus controller.
//   bus_state_t  - bus-cycle FSM state encoding
//   Def*         - default parameter values used by as1802_bus_ctrl
//   TimeoutFill  - read data returned to the core when a ready handshake times out
package as1802_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWaitRdy,
        StHold
    } bus_state_t;

    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefWaitW = 3;
    localparam int unsigned DefToW   = 8;
    localparam int unsigned DefNW    = 3;

    localparam logic [DefDataW-1:0] TimeoutFill = '1;

endpackage

// File: rtl/as1802_wait_cnt.sv
// as1802_wait_cnt: loadable down-counter with zero flag.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   load_i         - load load_val_i (has priority over dec_i)
//   load_val_i     - value to load
//   dec_i          - decrement by one; saturates at zero
//   zero_o         - count is zero
module as1802_wait_cnt #(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/as1802_bus_ctrl.sv
// as1802_bus_ctrl: external-bus controller between the as1802 core and the pads.
//   Core side : core_addr/core_tpa (multiplexed address), core_mrd/core_mwr (active-low
//               requests), core_dout, core_n, core_din (captured read data), core_ce (stall).
//   Pad side  : mem_addr, mem_rd_n/mem_wr_n (shaped strobes), mem_dout, mem_oeb, mem_din,
//               mem_ready, io_sel (one-hot N decode).
//   Config    : cfg_setup/cfg_wait/cfg_hold/cfg_use_rdy, sampled when a cycle starts.
//   Status    : err_timeout, sticky until reset.
// All outputs are registered; they are computed from the next FSM state.
module as1802_bus_ctrl
    import as1802_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned WAIT_W = DefWaitW,
    parameter int unsigned TO_W   = DefToW,
    parameter int unsigned N_W    = DefNW
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_n,
    input  logic [ADDR_W/2-1:0]   core_addr,
    input  logic                  core_tpa,
    input  logic                  core_mrd,
    input  logic                  core_mwr,
    input  logic [DATA_W-1:0]     core_dout,
    input  logic [N_W-1:0]        core_n,
    output logic [DATA_W-1:0]     core_din,
    output logic                  core_ce,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd_n,
    output logic                  mem_wr_n,
    output logic [DATA_W-1:0]     mem_dout,
    output logic                  mem_oeb,
    input  logic [DATA_W-1:0]     mem_din,
    input  logic                  mem_ready,
    output logic [(1<<N_W)-2:0]   io_sel,
    input  logic                  cfg_setup,
    input  logic [WAIT_W-1:0]     cfg_wait,
    input  logic                  cfg_hold,
    input  logic                  cfg_use_rdy,
    output logic                  err_timeout
);

    localparam int unsigned HalfW = ADDR_W / 2;
    localparam int unsigned IoW   = (1 << N_W) - 1;
    // WAIT_RDY lasts load+1 cycles, so this gives 2^TO_W-1 cycles before timing out.
    localparam logic [TO_W-1:0] ToLoad = {{(TO_W-1){1'b1}}, 1'b0};

    bus_state_t state_q, state_d;

    logic [HalfW-1:0]  addr_hi_q;
    logic              armed_q, armed_d;
    logic              is_wr_q, is_wr_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [WAIT_W-1:0] cfg_wait_q, cfg_wait_d;
    logic              cfg_hold_q, cfg_hold_d;
    logic              cfg_use_rdy_q, cfg_use_rdy_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
    logic [DATA_W-1:0] core_din_q, core_din_d;
    logic              err_q, err_d;
    logic              mem_rd_n_q, mem_wr_n_q, mem_oeb_q, core_ce_q;
    logic [IoW-1:0]    io_sel_q, io_sel_d;

    logic              start;
    logic              strobe_d;
    bus_state_t        exit_state;

    logic              wait_load, wait_dec, wait_zero;
    logic [WAIT_W-1:0] wait_load_val;
    logic              to_load, to_dec, to_zero;

    as1802_wait_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk_i      (wb_clk_i),
        .rst_ni     (rst_n),
        .load_i     (wait_load),
        .load_val_i (wait_load_val),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero)
    );

    as1802_wait_cnt #(.W(TO_W)) u_to_cnt (
        .clk_i      (wb_clk_i),
        .rst_ni     (rst_n),
        .load_i     (to_load),
        .load_val_i (ToLoad),
        .dec_i      (to_dec),
        .zero_o     (to_zero)
    );

    // A request only starts a cycle after both requests were seen high in IDLE.
    assign start         = armed_q && (!core_mrd || !core_mwr);
    assign exit_state    = cfg_hold_q ? StHold : StIdle;
    assign wait_load_val = (state_q == StIdle) ? cfg_wait : cfg_wait_q;

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        is_wr_d       = is_wr_q;
        n_d           = n_q;
        cfg_wait_d    = cfg_wait_q;
        cfg_hold_d    = cfg_hold_q;
        cfg_use_rdy_d = cfg_use_rdy_q;
        mem_addr_d    = mem_addr_q;
        mem_dout_d    = mem_dout_q;
        core_din_d    = core_din_q;
        err_d         = err_q;
        wait_load     = 1'b0;
        wait_dec      = 1'b0;
        to_load       = 1'b0;
        to_dec        = 1'b0;

        unique case (state_q)
            StIdle: begin
                armed_d = core_mrd && core_mwr;
                if (start) begin
                    is_wr_d       = !core_mwr;  // write wins over a simultaneous read
                    n_d           = core_n;
                    cfg_wait_d    = cfg_wait;
                    cfg_hold_d    = cfg_hold;
                    cfg_use_rdy_d = cfg_use_rdy;
                    mem_addr_d    = {addr_hi_q, core_addr};
                    mem_dout_d    = core_dout;
                    if (cfg_setup) begin
                        state_d = StSetup;
                    end else begin
                        state_d   = StStrobe;
                        wait_load = 1'b1;
                    end
                end
            end
            StSetup: begin
                state_d   = StStrobe;
                wait_load = 1'b1;
            end
            StStrobe: begin
                if (!wait_zero) begin
                    wait_dec = 1'b1;
                end else if (cfg_use_rdy_q && !mem_ready) begin
                    state_d = StWaitRdy;
                    to_load = 1'b1;
                end else begin
                    if (!is_wr_q) core_din_d = mem_din;
                    state_d = exit_state;
                end
            end
            StWaitRdy: begin
                if (mem_ready) begin
                    if (!is_wr_q) core_din_d = mem_din;
                    state_d = exit_state;
                end else if (to_zero) begin
                    err_d      = 1'b1;
                    core_din_d = {DATA_W{1'b1}};
                    state_d    = exit_state;
                end else begin
                    to_dec = 1'b1;
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        strobe_d = (state_d == StStrobe) || (state_d == StWaitRdy);
        io_sel_d = '0;
        if (strobe_d && (n_d != '0)) begin
            io_sel_d = IoW'(1) << (n_d - N_W'(1));
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            addr_hi_q     <= '0;
            armed_q       <= 1'b0;
            is_wr_q       <= 1'b0;
            n_q           <= '0;
            cfg_wait_q    <= '0;
            cfg_hold_q    <= 1'b0;
            cfg_use_rdy_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_dout_q    <= '0;
            core_din_q    <= '0;
            err_q         <= 1'b0;
            mem_rd_n_q    <= 1'b1;
            mem_wr_n_q    <= 1'b1;
            mem_oeb_q     <= 1'b1;
            core_ce_q     <= 1'b1;
            io_sel_q      <= '0;
        end else begin
            state_q       <= state_d;
            if (core_tpa) addr_hi_q <= core_addr;
            armed_q       <= armed_d;
            is_wr_q       <= is_wr_d;
            n_q           <= n_d;
            cfg_wait_q    <= cfg_wait_d;
            cfg_hold_q    <= cfg_hold_d;
            cfg_use_rdy_q <= cfg_use_rdy_d;
            mem_addr_q    <= mem_addr_d;
            mem_dout_q    <= mem_dout_d;
            core_din_q    <= core_din_d;
            err_q         <= err_d;
            mem_rd_n_q    <= !(strobe_d && !is_wr_d);
            mem_wr_n_q    <= !(strobe_d && is_wr_d);
            mem_oeb_q     <= !((state_d != StIdle) && is_wr_d);
            core_ce_q     <= (state_d == StIdle);
            io_sel_q      <= io_sel_d;
        end
    end

    assign core_din    = core_din_q;
    assign core_ce     = core_ce_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_n    = mem_rd_n_q;
    assign mem_wr_n    = mem_wr_n_q;
    assign mem_dout    = mem_dout_q;
    assign mem_oeb     = mem_oeb_q;
    assign io_sel      = io_sel_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_as1802_bus_ctrl.sv
// tb_as1802_bus_ctrl: table-driven bench for as1802_bus_ctrl plus hand-written sequences
// for re-arm and asynchronous reset during a write strobe.
module tb_as1802_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  core_addr = '0;
    logic        core_tpa = 1'b0;
    logic        core_mrd = 1'b1;
    logic        core_mwr = 1'b1;
    logic [7:0]  core_dout = '0;
    logic [2:0]  core_n = '0;
    logic [7:0]  core_din;
    logic        core_ce;
    logic [15:0] mem_addr;
    logic        mem_rd_n;
    logic        mem_wr_n;
    logic [7:0]  mem_dout;
    logic        mem_oeb;
    logic [7:0]  mem_din = '0;
    logic        mem_ready = 1'b0;
    logic [6:0]  io_sel;
    logic        cfg_setup = 1'b0;
    logic [2:0]  cfg_wait = '0;
    logic        cfg_hold = 1'b0;
    logic        cfg_use_rdy = 1'b0;
    logic        err_timeout;

    int n_pass = 0;
    int n_total = 0;

    as1802_bus_ctrl dut (
        .wb_clk_i    (clk),
        .rst_n       (rst_n),
        .core_addr   (core_addr),
        .core_tpa    (core_tpa),
        .core_mrd    (core_mrd),
        .core_mwr    (core_mwr),
        .core_dout   (core_dout),
        .core_n      (core_n),
        .core_din    (core_din),
        .core_ce     (core_ce),
        .mem_addr    (mem_addr),
        .mem_rd_n    (mem_rd_n),
        .mem_wr_n    (mem_wr_n),
        .mem_dout    (mem_dout),
        .mem_oeb     (mem_oeb),
        .mem_din     (mem_din),
        .mem_ready   (mem_ready),
        .io_sel      (io_sel),
        .cfg_setup   (cfg_setup),
        .cfg_wait    (cfg_wait),
        .cfg_hold    (cfg_hold),
        .cfg_use_rdy (cfg_use_rdy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_wr;
        logic       setup;
        logic [2:0] wait_n;
        logic       hold;
        logic       use_rdy;
        int         rdy_dly;   // strobe-cycle index at which mem_ready rises; -1 = never
        logic [2:0] n;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] dout;
        logic [7:0] din;
        int         e_rd;
        int         e_wr;
        int         e_ce;
        int         e_oeb;
        logic [15:0] e_addr;
        logic [7:0] e_din;
        logic       e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] onehot(input logic [2:0] n);
        logic [6:0] r;
        r = '0;
        if (n != 3'd0) r[n-3'd1] = 1'b1;
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input int idx);
        int  rd_low, wr_low, ce_low, oeb_low, io_err, st;
        bit  seen_low, done;
        logic [6:0] exp_io;
        string tag;
        rd_low = 0; wr_low = 0; ce_low = 0; oeb_low = 0; io_err = 0;
        seen_low = 0; done = 0;
        tag = $sformatf("v%0d", idx);

        core_tpa  = 1'b1;
        core_addr = v.hi;
        tick();
        core_tpa    = 1'b0;
        core_addr   = v.lo;
        cfg_setup   = v.setup;
        cfg_wait    = v.wait_n;
        cfg_hold    = v.hold;
        cfg_use_rdy = v.use_rdy;
        core_n      = v.n;
        core_dout   = v.dout;
        mem_ready   = 1'b0;
        mem_din     = v.use_rdy ? ~v.din : v.din;
        if (v.is_wr) core_mwr = 1'b0;
        else         core_mrd = 1'b0;

        for (int c = 0; c < 400; c++) begin
            tick();
            if (!mem_rd_n) rd_low++;
            if (!mem_wr_n) wr_low++;
            if (!mem_oeb)  oeb_low++;
            st = rd_low + wr_low;
            exp_io = (!mem_rd_n || !mem_wr_n) ? onehot(v.n) : 7'd0;
            if (io_sel !== exp_io) io_err++;
            if (v.use_rdy && (v.rdy_dly >= 0) && (!mem_rd_n || !mem_wr_n)
                && (st - 1 == v.rdy_dly)) begin
                mem_ready = 1'b1;
                mem_din   = v.din;
            end
            if (!core_ce) begin
                ce_low++;
                seen_low = 1;
            end else if (seen_low) begin
                done = 1;
                break;
            end
        end

        check({tag, " completes"}, 32'(done), 32'd1);
        check({tag, " rd_low"}, rd_low, v.e_rd);
        check({tag, " wr_low"}, wr_low, v.e_wr);
        check({tag, " ce_low"}, ce_low, v.e_ce);
        check({tag, " oeb_low"}, oeb_low, v.e_oeb);
        check({tag, " io_sel"}, io_err, 0);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
        check({tag, " core_din"}, 32'(core_din), 32'(v.e_din));
        check({tag, " err_timeout"}, 32'(err_timeout), 32'(v.e_err));
        if (v.is_wr) check({tag, " mem_dout"}, 32'(mem_dout), 32'(v.dout));

        core_mrd  = 1'b1;
        core_mwr  = 1'b1;
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_low, wr_low, ce_low;
        bit found;
        vec_t vp;

        // is_wr setup wait hold rdy dly n hi lo dout din | rd wr ce oeb addr din err
        vecs[0] = '{0, 0, 3'd0, 0, 0, -1, 3'd0, 8'h12, 8'h34, 8'h00, 8'hA5,
                    1, 0, 1, 0, 16'h1234, 8'hA5, 0};
        vecs[1] = '{1, 1, 3'd2, 1, 0, -1, 3'd0, 8'hAB, 8'hCD, 8'h5A, 8'hEE,
                    0, 3, 5, 5, 16'hABCD, 8'hA5, 0};
        vecs[2] = '{1, 0, 3'd1, 0, 0, -1, 3'd3, 8'h56, 8'h03, 8'hC3, 8'hEE,
                    0, 2, 2, 2, 16'h5603, 8'hA5, 0};
        vecs[3] = '{0, 0, 3'd0, 0, 1, 6, 3'd0, 8'h80, 8'h01, 8'h00, 8'h77,
                    7, 0, 7, 0, 16'h8001, 8'h77, 0};
        vecs[4] = '{0, 1, 3'd0, 1, 0, -1, 3'd5, 8'h00, 8'hFF, 8'h00, 8'h3C,
                    1, 0, 3, 0, 16'h00FF, 8'h3C, 0};
        vecs[5] = '{0, 0, 3'd2, 0, 1, 0, 3'd0, 8'h40, 8'h10, 8'h00, 8'h11,
                    3, 0, 3, 0, 16'h4010, 8'h11, 0};
        vecs[6] = '{0, 0, 3'd0, 0, 1, -1, 3'd0, 8'hDE, 8'hAD, 8'h00, 8'h99,
                    256, 0, 256, 0, 16'hDEAD, 8'hFF, 1};
        vecs[7] = '{0, 0, 3'd0, 0, 0, -1, 3'd7, 8'h0F, 8'hF0, 8'h00, 8'h42,
                    1, 0, 1, 0, 16'h0FF0, 8'h42, 1};

        // Reset state
        #12;
        check("rst core_ce", 32'(core_ce), 32'd1);
        check("rst mem_rd_n", 32'(mem_rd_n), 32'd1);
        check("rst mem_wr_n", 32'(mem_wr_n), 32'd1);
        check("rst mem_oeb", 32'(mem_oeb), 32'd1);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_dout", 32'(mem_dout), 32'd0);
        check("rst core_din", 32'(core_din), 32'd0);
        check("rst io_sel", 32'(io_sel), 32'd0);
        check("rst err_timeout", 32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Held read request must produce exactly one strobe.
        core_tpa = 1'b1; core_addr = 8'h21; tick();
        core_tpa = 1'b0; core_addr = 8'h43;
        cfg_setup = 0; cfg_wait = 0; cfg_hold = 0; cfg_use_rdy = 0; core_n = 0;
        core_mrd = 1'b0;
        rd_low = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (!mem_rd_n) rd_low++;
        end
        check("rearm single strobe", rd_low, 1);
        check("rearm core_ce idle", 32'(core_ce), 32'd1);
        core_mrd = 1'b1;
        tick();

        // Asynchronous reset in the middle of a write strobe.
        core_tpa = 1'b1; core_addr = 8'h99; tick();
        core_tpa = 1'b0; core_addr = 8'h88;
        cfg_wait = 3'd4; core_dout = 8'h66;
        core_mwr = 1'b0;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!mem_wr_n) begin
                found = 1;
                break;
            end
        end
        check("rstmid strobe seen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid mem_wr_n", 32'(mem_wr_n), 32'd1);
        check("rstmid mem_oeb", 32'(mem_oeb), 32'd1);
        check("rstmid core_ce", 32'(core_ce), 32'd1);
        check("rstmid err_timeout", 32'(err_timeout), 32'd0);
        check("rstmid mem_addr", 32'(mem_addr), 32'd0);
        #2 rst_n = 1'b1;
        wr_low = 0; ce_low = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (!mem_wr_n) wr_low++;
            if (!core_ce) ce_low++;
        end
        check("rstmid no retrigger wr", wr_low, 0);
        check("rstmid no retrigger ce", ce_low, 0);
        core_mwr = 1'b1;
        tick();

        // Recovery after reset: plain read works again.
        vp = '{0, 0, 3'd0, 0, 0, -1, 3'd1, 8'h5A, 8'hA5, 8'h00, 8'hC7,
               1, 0, 1, 0, 16'h5AA5, 8'hC7, 0};
        run_txn(vp, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
